bus_arbiter_5: RTL
==================

// Module: bus_arbiter_5
// PURPOSE
//   Round-robin arbiter sharing one 32-bit 5:1 datapath mux between 5 requesters.
//   Drives the mux 3-bit selector plus a one-hot grant, and enforces a bounded hold time.
//   Inserts one dead cycle between owners so the mux output never switches under an active grant.
//   Sits beside the mux5_5 instance in the datapath; the mux itself is unchanged.
// PARAMETERS
//   MAX_HOLD  16  max consecutive GRANT cycles while others wait; 0 = no preemption
//   CNT_W     5   hold counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//   clk       in   1  single clock, all state updates on rising edge
//   reset     in   1  synchronous, active-low (sampled at posedge clk; 0 = reset)
//   req       in   5  req[i]=1: requester i wants the mux; held until done with bus
//   grant     out  5  one-hot owner, zero when no owner; registered
//   selector  out  3  to mux selector; index of current/last owner; registered
//   bus_busy  out  1  =|grant
//   owner_id  out  3  index of current owner, valid while bus_busy=1
// BEHAVIOUR
//   Reset: state=IDLE, grant=0, selector=3'b000, bus_busy=0, owner_id=0,
//     hold_cnt=0, last_owner=4 so requester 0 has top priority after reset.
//   Pick: first i with req[i]=1, scanning last_owner+1, +2, ... mod 5.
//     The 4->0 wrap is mandatory. The scan includes last_owner itself as the final candidate.
//   FSM states: IDLE, GRANT, TURN.
//   IDLE: if |req: next edge -> GRANT; grant=onehot(pick), selector=owner_id=pick,
//     last_owner=pick, hold_cnt=0. Otherwise stay IDLE with outputs unchanged.
//     Latency: req rises in cycle n -> grant high in cycle n+1.
//   GRANT: hold_cnt += 1, saturating at 2**CNT_W-1.
//     Release when req[owner]=0 -> TURN.
//     Preempt when MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and any other req set -> TURN.
//     Release and preempt in the same cycle -> TURN (same result).
//     Otherwise stay in GRANT.
//   TURN: exactly one cycle with grant=0, bus_busy=0; selector holds the old value.
//     Next edge: if |req -> GRANT with a new pick (as in IDLE); else -> IDLE.
//   selector changes only on the edge entering GRANT; it never changes while bus_busy=1.
//   No req while IDLE: no output toggles.
//   Preempted owner keeping req high re-enters arbitration at lowest priority.
//   Reset asserted mid-GRANT: grant=0 at that same edge; no TURN cycle is inserted.
//   Illegal FSM encoding -> IDLE (default arm).
// STRUCTURE
//   arb_pkg: localparams N_REQ=5, SEL_W=3, state encodings ST_IDLE/ST_GRANT/ST_TURN.
//   Sub-module rr_pick5 (combinational): inputs req[4:0], last_owner[2:0];
//     outputs pick[2:0], any. It contains the rotating-priority scan.
//   Top: FSM, hold counter, and output registers.
// TESTING
//   Reset: hold reset=0 for 2 cycles with req=5'b11111 -> grant=0, selector=0,
//     bus_busy=0; release reset -> grant=5'b00001 one cycle later.
//   Single requester: req=5'b00100 for 3 cycles then 0 -> grant=5'b00100 cycles 1-3,
//     selector=2, then one TURN cycle, then IDLE.
//   Rotation: req=5'b10011, each owner drops req after 2 cycles -> grant order 0,1,4,
//     with one zero-grant cycle between each.
//   Wrap: last_owner=4, req=5'b10001 -> grant requester 0, not 4.
//   Preempt: MAX_HOLD=4; req[3] held high, req[1] rises -> owner 3 loses grant after
//     its 4th cycle, TURN, then grant=5'b00010. With MAX_HOLD=0, requester 3 keeps grant.
//   Mid-operation reset: reset=0 during GRANT -> grant=0 at that edge;
//     after release, requester 0 wins if requesting.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants, FSM state encoding and one-hot helper for the 5-way round-robin bus arbiter.
package arb_pkg;
    localparam int N_REQ = 5;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_e;

    function automatic logic [N_REQ-1:0] onehot_of(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
        return v;
    endfunction
endpackage

// File: rtl/rr_pick5.sv
// Rotating-priority scan: first requester after last_owner (mod 5), with last_owner itself checked last.
module rr_pick5
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last_owner,
    output logic [SEL_W-1:0] pick,
    output logic             any
);
    localparam logic [SEL_W-1:0] TOP_IDX = SEL_W'(N_REQ - 1);

    logic [SEL_W-1:0] cand_s;

    // Walk the five candidates in rotating order and latch the first hit.
    always_comb begin
        pick   = {SEL_W{1'b0}};
        any    = 1'b0;
        // An out-of-range last_owner behaves like the top index so 0 is scanned first.
        cand_s = (last_owner > TOP_IDX) ? TOP_IDX : last_owner;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = (cand_s == TOP_IDX) ? {SEL_W{1'b0}} : cand_s + SEL_W'(1);
            pick   = (!any && req[cand_s]) ? cand_s : pick;
            any    = any | req[cand_s];
        end
    end
endmodule

// File: rtl/bus_arbiter_5.sv
// Round-robin owner for a shared 5:1 datapath mux with bounded hold time and a dead cycle between owners.
module bus_arbiter_5
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] selector,
    output logic             bus_busy,
    output logic [SEL_W-1:0] owner_id
);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT   = {CNT_W{1'b1}};
    localparam bit               PREEMPT_EN = (MAX_HOLD != 0);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] owner_q, owner_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic [SEL_W-1:0] pick_s;
    logic             any_s;
    logic             release_s;
    logic             others_s;
    logic             preempt_s;

    rr_pick5 u_pick (
        .req        (req),
        .last_owner (last_q),
        .pick       (pick_s),
        .any        (any_s)
    );

    // Next-state and next-output logic for the IDLE/GRANT/TURN controller.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;

        release_s = ~|(req & grant_q);
        others_s  = |(req & ~grant_q);
        preempt_s = PREEMPT_EN && (hold_q == HOLD_LAST) && others_s;

        case (state_q)
            ST_IDLE, ST_TURN: begin
                // The selector only moves here, while grant is still zero.
                if (any_s) begin
                    state_d = ST_GRANT;
                    grant_d = onehot_of(pick_s);
                    sel_d   = pick_s;
                    owner_d = pick_s;
                    last_d  = pick_s;
                    hold_d  = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                    grant_d = {N_REQ{1'b0}};
                end
            end
            ST_GRANT: begin
                hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + CNT_W'(1);
                if (release_s || preempt_s) begin
                    state_d = ST_TURN;
                    grant_d = {N_REQ{1'b0}};
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = {N_REQ{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= {N_REQ{1'b0}};
            sel_q   <= {SEL_W{1'b0}};
            owner_q <= {SEL_W{1'b0}};
            last_q  <= SEL_W'(N_REQ - 1);
            hold_q  <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign grant    = grant_q;
    assign selector = sel_q;
    assign owner_id = owner_q;
    assign bus_busy = |grant_q;
endmodule
